memory_access: RTL

- MEM stage of the 5-stage pipeline; sits directly downstream of the execute stage and consumes its EX/MEM outputs: WB/MEM control, ALU result, forwarded rt value and destination register.
- Performs byte, halfword and word loads and stores on a local data RAM. Memory latency is configurable; the stage stalls upstream while an access is in wait states.
- Produces the MEM/WB pipeline register for the writeback stage and a debug read port for the debug unit.

---
 rtl/mem_stage_pkg.sv | 27 ++
 rtl/memory_access_if.sv | 26 ++
 rtl/memory_access_data_memory.sv | 27 ++
 rtl/memory_access.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access types, control-bit
// positions inside the EX/MEM bundles, and the wait-state FSM encoding.
package mem_stage_pkg;

  localparam logic [2:0] LS_LB  = 3'b000;
  localparam logic [2:0] LS_LH  = 3'b001;
  localparam logic [2:0] LS_W   = 3'b010;
  localparam logic [2:0] LS_LBU = 3'b100;
  localparam logic [2:0] LS_LHU = 3'b101;

  localparam int MEM_WR     = 0;
  localparam int MEM_RD     = 1;
  localparam int MEM_BR     = 2;
  localparam int WB_REGWR   = 0;
  localparam int WB_MEM2REG = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Size code is lsType[1:0]: 00 byte, 01 halfword, 1x word.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    isMisaligned = (size == 2'b01) ? lane[0] : (size[1] ? (lane != 2'b00) : 1'b0);
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage, bundled as one port.
interface memory_access_if;
  // stall=1 asks upstream to hold every in_* field unchanged; the stage
  // consumes the in_* bundle on the first falling edge where stall=0.
  logic [1:0]  in_wb;
  logic [2:0]  in_mem;
  logic [2:0]  in_ls_type;
  logic [31:0] in_alu_result;
  logic [31:0] in_reg_b;
  logic [4:0]  in_wreg;
  logic        stall;
  logic [1:0]  out_wb;
  logic [31:0] out_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_wreg;

  modport master (
    output in_wb, in_mem, in_ls_type, in_alu_result, in_reg_b, in_wreg,
    input  stall, out_wb, out_read_data, out_alu_result, out_wreg
  );

  modport slave (
    input  in_wb, in_mem, in_ls_type, in_alu_result, in_reg_b, in_wreg,
    output stall, out_wb, out_read_data, out_alu_result, out_wreg
  );
endinterface

// File: rtl/memory_access_data_memory.sv
// Word-organised data RAM: byte-enabled falling-edge write, combinational
// access read port and an independent combinational debug read port.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 8
) (
  input  logic                  clk,
  input  logic [3:0]            byteEn,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic [DATA_WIDTH-1:0] rData,
  input  logic [ADDR_BITS-1:0]  dbgAddr,
  output logic [DATA_WIDTH-1:0] dbgData
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) mem[addr][8*i +: 8] <= wData[8*i +: 8];
    end
  end

  assign rData   = mem[addr];
  assign dbgData = mem[dbgAddr];

endmodule

// File: rtl/memory_access.sv
// MEM stage: alignment check, byte-lane steering/extension, latency FSM that
// stalls upstream during wait states, and the MEM/WB pipeline register.
module memory_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_BITS   = 8,
  parameter int MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_access_if.slave        bus,
  input  logic [ADDR_BITS-1:0]  dbg_addr,
  output logic                  align_fault,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output mem_state_t            fsmState
);

  localparam logic [2:0] CNT_LOAD = (MEM_LATENCY > 0) ? 3'(MEM_LATENCY - 1) : 3'd0;

  mem_state_t state, nextState;
  logic [2:0] cnt, cntNext;

  logic                  isAccess, isWrite, isRead, misaligned, complete;
  logic [1:0]            size, lane;
  logic [ADDR_BITS-1:0]  wordAddr;
  logic [3:0]            byteEn;
  logic [DATA_WIDTH-1:0] wData, rWord, byteShift, halfShift, extData, loadData;
  logic                  unusedBits;

  assign isAccess   = bus.in_mem[MEM_WR] | bus.in_mem[MEM_RD];
  assign isWrite    = bus.in_mem[MEM_WR];
  assign isRead     = bus.in_mem[MEM_RD] & ~bus.in_mem[MEM_WR];
  assign size       = bus.in_ls_type[1:0];
  assign lane       = bus.in_alu_result[1:0];
  assign wordAddr   = bus.in_alu_result[ADDR_BITS+1:2];
  assign misaligned = isAccess & isMisaligned(size, lane);
  assign unusedBits = ^{bus.in_mem[MEM_BR], bus.in_alu_result[DATA_WIDTH-1:ADDR_BITS+2]};

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      ST_IDLE: begin
        if (isAccess && !misaligned && (MEM_LATENCY > 0)) begin
          nextState = ST_WAIT;
          cntNext   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt != 3'd0) cntNext = cnt - 3'd1;
        else             nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.stall = 1'b0;
    case (state)
      ST_IDLE: bus.stall = isAccess && !misaligned && (MEM_LATENCY > 0);
      ST_WAIT: bus.stall = (cnt != 3'd0);
      default: bus.stall = 1'b0;
    endcase
  end

  assign complete = ~bus.stall;
  assign fsmState = state;

  // Write strobes are gated by rst so a reset mid-wait never commits a store.
  always_comb begin
    byteEn = 4'b0000;
    wData  = bus.in_reg_b;
    case (size)
      2'b00: begin
        byteEn = 4'b0001 << lane;
        wData  = {4{bus.in_reg_b[7:0]}};
      end
      2'b01: begin
        byteEn = lane[1] ? 4'b1100 : 4'b0011;
        wData  = {2{bus.in_reg_b[15:0]}};
      end
      default: byteEn = 4'b1111;
    endcase
    if (!(complete && isWrite && !misaligned && !rst)) byteEn = 4'b0000;
  end

  data_memory #(.DATA_WIDTH(DATA_WIDTH), .ADDR_BITS(ADDR_BITS)) u_ram (
    .clk     (clk),
    .byteEn  (byteEn),
    .addr    (wordAddr),
    .wData   (wData),
    .rData   (rWord),
    .dbgAddr (dbg_addr),
    .dbgData (dbg_data)
  );

  assign byteShift = rWord >> {lane, 3'b000};
  assign halfShift = rWord >> {lane[1], 4'b0000};

  always_comb begin
    case (bus.in_ls_type)
      LS_LB:   extData = {{24{byteShift[7]}}, byteShift[7:0]};
      LS_LH:   extData = {{16{halfShift[15]}}, halfShift[15:0]};
      LS_LBU:  extData = {24'd0, byteShift[7:0]};
      LS_LHU:  extData = {16'd0, halfShift[15:0]};
      default: extData = rWord;
    endcase
  end

  assign loadData = (isRead && !misaligned) ? extData : '0;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.out_wb         <= 2'b00;
      bus.out_read_data  <= '0;
      bus.out_alu_result <= '0;
      bus.out_wreg       <= 5'd0;
      align_fault        <= 1'b0;
    end else if (bus.stall) begin
      bus.out_wb         <= 2'b00;
      bus.out_read_data  <= '0;
      bus.out_alu_result <= '0;
      bus.out_wreg       <= 5'd0;
    end else begin
      bus.out_wb         <= misaligned ? 2'b00 : bus.in_wb;
      bus.out_read_data  <= loadData;
      bus.out_alu_result <= bus.in_alu_result;
      bus.out_wreg       <= bus.in_wreg;
      if (misaligned) align_fault <= 1'b1;
    end
  end

endmodule
